// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state and command layout for the 4-bit ALU driver.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MAX = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic       use_acc;
    logic [2:0] op;
    logic [3:0] b;
    logic [3:0] a;
  } cmd_t;

  function automatic logic is_illegal(input logic [2:0] op);
    return (op > OP_MAX);
  endfunction

endpackage

// File: rtl/alu_4bit_driver_if.sv
// Command and response channels of the ALU driver, plus FIFO occupancy.
interface alu_4bit_driver_if #(
  parameter int LVL_W = 3
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_a;
  logic [3:0]       cmd_b;
  logic [2:0]       cmd_op;
  logic             cmd_use_acc;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [3:0]       rsp_result;
  logic             rsp_zero;
  logic             rsp_illegal;
  logic [LVL_W-1:0] cmd_level;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_use_acc, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_result, rsp_zero, rsp_illegal, cmd_level
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_use_acc, rsp_ready,
    output cmd_ready, rsp_valid, rsp_result, rsp_zero, rsp_illegal, cmd_level
  );
endinterface

// File: rtl/alu_cmd_fifo.sv
// Registered command FIFO (no fall-through); DEPTH must be a power of two.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  cmd_t             wdata,
  input  logic             pop,
  output cmd_t             rdata,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);
  localparam int PW = $clog2(DEPTH);

  cmd_t             mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [LVL_W-1:0] level_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (level_r == LVL_W'(DEPTH));
  assign empty     = (level_r == LVL_W'(0));
  assign level     = level_r;
  assign rdata     = mem_r[rd_ptr_r];
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= PW'(0);
      rd_ptr_r <= PW'(0);
      level_r  <= LVL_W'(0);
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   level_r <= level_r + LVL_W'(1);
        2'b01:   level_r <= level_r - LVL_W'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r] <= wdata;
  end
endmodule

// File: rtl/alu_4bit_driver.sv
// Issues queued commands one at a time to a combinational 4-bit ALU and
// returns captured results; optional accumulator chaining via use_acc.
module alu_4bit_driver
  import alu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  alu_4bit_driver_if.slave    bus,
  output logic [3:0]          alu_a,
  output logic [3:0]          alu_b,
  output logic [2:0]          alu_opcode,
  input  logic [3:0]          alu_result,
  input  logic                alu_zero
);
  state_e     state_r;
  state_e     next_state_s;
  cmd_t       push_data_s;
  cmd_t       head_s;
  logic       full_s;
  logic       empty_s;
  logic       push_s;
  logic       pop_s;
  logic       capture_s;
  logic [3:0] acc_r;
  logic [3:0] alu_a_r;
  logic [3:0] alu_b_r;
  logic [2:0] alu_opcode_r;
  logic       rsp_valid_r;
  logic [3:0] rsp_result_r;
  logic       rsp_zero_r;
  logic       rsp_illegal_r;

  assign push_data_s   = '{use_acc: bus.cmd_use_acc, op: bus.cmd_op, b: bus.cmd_b, a: bus.cmd_a};
  assign bus.cmd_ready = !full_s && !rst;
  assign push_s        = bus.cmd_valid && bus.cmd_ready;

  alu_cmd_fifo #(.DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .wdata (push_data_s),
    .pop   (pop_s),
    .rdata (head_s),
    .full  (full_s),
    .empty (empty_s),
    .level (bus.cmd_level)
  );

  // Next-state and pop/capture strobes.
  always_comb begin
    next_state_s = state_r;
    pop_s        = 1'b0;
    capture_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_s) begin
          next_state_s = EXEC;
          pop_s        = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      EXEC: begin
        next_state_s = RESP;
        capture_s    = 1'b1;
      end
      RESP: begin
        if (bus.rsp_ready) next_state_s = IDLE;
        else               next_state_s = RESP;
      end
      default: next_state_s = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= next_state_s;
  end

  // ALU operand issue, result capture and accumulator; all cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a_r       <= 4'd0;
      alu_b_r       <= 4'd0;
      alu_opcode_r  <= 3'd0;
      acc_r         <= 4'd0;
      rsp_valid_r   <= 1'b0;
      rsp_result_r  <= 4'd0;
      rsp_zero_r    <= 1'b0;
      rsp_illegal_r <= 1'b0;
    end else begin
      if (pop_s) begin
        alu_a_r      <= head_s.use_acc ? acc_r : head_s.a;
        alu_b_r      <= head_s.b;
        alu_opcode_r <= head_s.op;
      end
      if (capture_s) begin
        rsp_result_r  <= alu_result;
        rsp_zero_r    <= alu_zero;
        rsp_illegal_r <= is_illegal(alu_opcode_r);
        acc_r         <= alu_result;
      end
      if (capture_s)                             rsp_valid_r <= 1'b1;
      else if (state_r == RESP && bus.rsp_ready) rsp_valid_r <= 1'b0;
    end
  end

  assign alu_a           = alu_a_r;
  assign alu_b           = alu_b_r;
  assign alu_opcode      = alu_opcode_r;
  assign bus.rsp_valid   = rsp_valid_r;
  assign bus.rsp_result  = rsp_result_r;
  assign bus.rsp_zero    = rsp_zero_r;
  assign bus.rsp_illegal = rsp_illegal_r;
endmodule

// File: tb/tb_alu_4bit_driver.sv
// Directed bench for alu_4bit_driver with an ALU model and a response scoreboard.
module tb_alu_4bit_driver;
  import alu_pkg::*;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  typedef struct {
    logic [3:0] res;
    logic       zero;
    logic       ill;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] alu_a, alu_b, alu_result;
  logic [2:0] alu_opcode;
  logic       alu_zero;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   hs_count = 0;
  int   last_hs = 0;
  logic track_spacing = 1'b0;
  logic hs_seen = 1'b0;
  logic cmd_fire = 1'b0;
  logic [3:0] acc_m = 4'd0;
  exp_t sb[$];

  always #5 clk = ~clk;

  alu_4bit_driver_if #(.LVL_W(LW)) bus ();

  alu_4bit_driver #(.FIFO_DEPTH(DEPTH), .LVL_W(LW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_result (alu_result),
    .alu_zero   (alu_zero)
  );

  // Stand-in for the existing combinational ALU.
  always_comb begin
    case (alu_opcode)
      3'b000:  alu_result = alu_a + alu_b;
      3'b001:  alu_result = alu_a - alu_b;
      3'b010:  alu_result = alu_a & alu_b;
      3'b011:  alu_result = alu_a | alu_b;
      3'b100:  alu_result = alu_a ^ alu_b;
      default: alu_result = 4'd0;
    endcase
  end
  assign alu_zero = (alu_result == 4'd0);

  function automatic logic [3:0] model_op(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return 4'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes at the falling edge, return 1 ns after the rising edge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    cmd_fire = bus.cmd_valid && bus.cmd_ready;
    if (bus.rsp_valid && bus.rsp_ready) begin
      hs_count++;
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("rsp_result", 32'(bus.rsp_result), 32'(e.res));
        chk("rsp_zero", 32'(bus.rsp_zero), 32'(e.zero));
        chk("rsp_illegal", 32'(bus.rsp_illegal), 32'(e.ill));
      end
      if (track_spacing && hs_seen) chk("rsp_spacing", 32'(cyc - last_hs), 32'd3);
      last_hs = cyc;
      hs_seen = 1'b1;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op, input logic use_acc);
    exp_t e;
    int   n;
    bus.cmd_valid   = 1'b1;
    bus.cmd_a       = a;
    bus.cmd_b       = b;
    bus.cmd_op      = op;
    bus.cmd_use_acc = use_acc;
    n = 0;
    cmd_fire = 1'b0;
    while (!cmd_fire && n < 20) begin
      cycle();
      n++;
    end
    bus.cmd_valid = 1'b0;
    if (cmd_fire) begin
      e.res  = model_op(use_acc ? acc_m : a, b, op);
      e.zero = (e.res == 4'd0);
      e.ill  = (op > 3'b100);
      acc_m  = e.res;
      sb.push_back(e);
    end else begin
      chk("cmd_timeout", 32'd1, 32'd0);
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    bus.rsp_ready = 1'b1;
    while (sb.size() > 0 && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_left", 32'(sb.size()), 32'd0);
    cycle();
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    int start;
    int n;
    rst             = 1'b1;
    bus.cmd_valid   = 1'b0;
    bus.cmd_a       = 4'd0;
    bus.cmd_b       = 4'd0;
    bus.cmd_op      = 3'd0;
    bus.cmd_use_acc = 1'b0;
    bus.rsp_ready   = 1'b0;
    cycle();
    cycle();
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_level", 32'(bus.cmd_level), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_alu_b", 32'(alu_b), 32'd0);
    chk("rst_alu_op", 32'(alu_opcode), 32'd0);
    chk("rst_rsp_result", 32'(bus.rsp_result), 32'd0);
    chk("rst_cmd_ready_after", 32'(bus.cmd_ready), 32'd1);

    // Single op with latency checks: pushed at T, issued T+1, captured T+2.
    send(4'd9, 4'd8, OP_ADD, 1'b0);
    chk("lat_t0_valid", 32'(bus.rsp_valid), 32'd0);
    chk("lat_t0_level", 32'(bus.cmd_level), 32'd1);
    cycle();
    chk("exec_alu_a", 32'(alu_a), 32'd9);
    chk("exec_alu_b", 32'(alu_b), 32'd8);
    chk("exec_alu_op", 32'(alu_opcode), 32'(OP_ADD));
    chk("exec_level", 32'(bus.cmd_level), 32'd0);
    chk("exec_valid", 32'(bus.rsp_valid), 32'd0);
    cycle();
    chk("lat_t2_valid", 32'(bus.rsp_valid), 32'd1);
    drain(5);
    chk("after_rsp_valid", 32'(bus.rsp_valid), 32'd0);

    // Zero flag and subtraction wrap.
    send(4'd5, 4'd5, OP_SUB, 1'b0);
    send(4'd2, 4'd3, OP_SUB, 1'b0);
    drain(20);

    // Accumulator chain: 3, 3+4=7, 7^7=0.
    send(4'd3, 4'd0, OP_OR, 1'b0);
    send(4'd0, 4'd4, OP_ADD, 1'b1);
    send(4'd0, 4'd7, OP_XOR, 1'b1);
    drain(30);

    // Illegal opcode, then a legal op clears the flag.
    send(4'hF, 4'hF, 3'b101, 1'b0);
    send(4'd1, 4'd2, OP_ADD, 1'b0);
    drain(20);

    // Backpressure: five pushes fill the FIFO after one pop.
    send(4'd1, 4'd2, OP_ADD, 1'b0);
    send(4'd7, 4'd3, OP_SUB, 1'b0);
    send(4'hC, 4'hA, OP_AND, 1'b0);
    send(4'd5, 4'hA, OP_OR, 1'b0);
    send(4'd6, 4'd3, OP_XOR, 1'b0);
    chk("full_level", 32'(bus.cmd_level), 32'd4);
    chk("full_ready", 32'(bus.cmd_ready), 32'd0);
    bus.cmd_valid   = 1'b1;
    bus.cmd_a       = 4'hE;
    bus.cmd_b       = 4'h1;
    bus.cmd_op      = OP_ADD;
    bus.cmd_use_acc = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_ready", 32'(bus.cmd_ready), 32'd0);
      chk("stall_level", 32'(bus.cmd_level), 32'd4);
      chk("stall_valid", 32'(bus.rsp_valid), 32'd1);
      chk("stall_result", 32'(bus.rsp_result), 32'd3);
    end
    bus.cmd_valid = 1'b0;
    track_spacing = 1'b1;
    hs_seen       = 1'b0;
    drain(40);
    track_spacing = 1'b0;

    // Reset while EXEC runs with two entries still queued.
    send(4'd1, 4'd1, OP_ADD, 1'b0);
    send(4'd4, 4'd2, OP_ADD, 1'b0);
    send(4'd8, 4'd1, OP_SUB, 1'b0);
    send(4'd9, 4'd9, OP_XOR, 1'b0);
    chk("pre_rst_level", 32'(bus.cmd_level), 32'd3);
    bus.rsp_ready = 1'b1;
    start = hs_count;
    n = 0;
    while (hs_count == start && n < 10) begin
      cycle();
      n++;
    end
    chk("pre_rst_hs", 32'(hs_count - start), 32'd1);
    bus.rsp_ready = 1'b0;
    cycle();
    chk("exec_q_level", 32'(bus.cmd_level), 32'd2);
    chk("exec_q_alu_a", 32'(alu_a), 32'd4);
    chk("exec_q_valid", 32'(bus.rsp_valid), 32'd0);
    rst = 1'b1;
    #1;
    chk("rst_hi_ready", 32'(bus.cmd_ready), 32'd0);
    cycle();
    rst = 1'b0;
    sb.delete();
    acc_m = 4'd0;
    #1;
    chk("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mid_rst_level", 32'(bus.cmd_level), 32'd0);
    chk("mid_rst_alu_a", 32'(alu_a), 32'd0);
    chk("mid_rst_result", 32'(bus.rsp_result), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("mid_rst_quiet", 32'(bus.rsp_valid), 32'd0);
    end
    send(4'd9, 4'd6, OP_ADD, 1'b1);
    drain(10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_4bit_driver.md
Name: alu_4bit_driver

Overview:
Sequential initiator for the 4-bit combinational ALU. It accepts operation commands on a valid/ready channel and buffers them in a small FIFO. It issues one command at a time to the ALU through registered operand/opcode ports, captures Result/Zero, and returns them on a valid/ready response channel. An optional accumulator mode feeds the previous result back as operand A, so ops can be chained.

Parameters:
FIFO_DEPTH, 4, command FIFO entries; power of two, >= 2
LVL_W, $clog2(FIFO_DEPTH)+1, width of cmd_level

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  FIFO can accept command
cmd_a  in  4  operand A
cmd_b  in  4  operand B
cmd_op  in  3  ALU opcode
cmd_use_acc  in  1  1: use accumulator instead of cmd_a
alu_a  out  4  registered operand A to ALU
alu_b  out  4  registered operand B to ALU
alu_opcode  out  3  registered opcode to ALU
alu_result  in  4  ALU Result (combinational from alu_*)
alu_zero  in  1  ALU Zero flag
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_result  out  4  captured result
rsp_zero  out  1  captured Zero
rsp_illegal  out  1  opcode was outside 000..100
cmd_level  out  LVL_W  current FIFO occupancy

Behaviour:
- Reset (rst=1 at an edge): FIFO emptied, state IDLE, accumulator=0. Outputs go to: alu_a=0, alu_b=0, alu_opcode=0, rsp_valid=0, rsp_result=0, rsp_zero=0, rsp_illegal=0, cmd_level=0. cmd_ready=0 while rst is high.
- Reset mid-operation discards any in-flight command and any pending response. There is no partial completion.
- cmd channel:
  - Push on an edge where cmd_valid & cmd_ready.
  - cmd_ready = !full. It is combinational from FIFO state only and never depends on cmd_valid.
  - When full, cmd_ready=0 even if a pop occurs in the same cycle. There is no full-bypass.
- FIFO: registered storage with no fall-through. Pointers wrap modulo FIFO_DEPTH. cmd_level updates on the edge of a push or pop; push and pop on the same edge leave it unchanged.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: if FIFO non-empty, pop the head at the edge and go to EXEC. The same edge loads the ALU registers:
    - alu_a = use_acc ? acc : a
    - alu_b = b
    - alu_opcode = op
    - If the FIFO is empty, stay in IDLE; alu_* hold their last values.
  - EXEC: alu_* are stable for one full cycle. At the edge, capture:
    - rsp_result = alu_result
    - rsp_zero = alu_zero
    - rsp_illegal = (alu_opcode > 3'b100)
    - acc = alu_result
    - Go to RESP.
  - RESP: rsp_valid=1. On the edge with rsp_ready=1, go to IDLE. Otherwise hold, with all rsp_* stable.
- The accumulator captures illegal-op results too; these are 0 from the ALU.
- rsp_valid = (state==RESP), driven from a register/decode, never from rsp_ready.
- Latency: command pushed at edge T into an empty FIFO with the FSM in IDLE:
  - pop/issue at edge T+1
  - capture at edge T+2
  - rsp_valid high during cycle T+2 → T+3
- Throughput: one op per 3 cycles with rsp_ready tied high.
- Arithmetic: all 4-bit wrap. The driver never inspects data except for the illegal-opcode compare.
- Pushes continue during EXEC/RESP until the FIFO is full.

Decomposition:
- Package alu_pkg:
  - opcode constants: OP_ADD=000, OP_SUB=001, OP_AND=010, OP_OR=011, OP_XOR=100
  - OP_MAX=100
  - state enum {IDLE, EXEC, RESP}
  - command struct {use_acc, op[2:0], b[3:0], a[3:0]}, 12 bits
- Sub-module alu_cmd_fifo: parameterised synchronous FIFO with push/pop/full/empty/level.
- Top module contains the FSM, accumulator and response registers. Bench instantiates the existing ALU wired to alu_*.

Test Plan:
- Reset then single op: push a=9, b=8, op=000 → rsp_valid at T+2, rsp_result=0001, rsp_zero=0, rsp_illegal=0. alu_a=9, alu_b=8 visible during EXEC.
- Zero/sub: push a=5, b=5, op=001 → rsp_result=0000, rsp_zero=1. Then a=2, b=3, op=001 → rsp_result=1111, rsp_zero=0.
- Accumulator chain: push a=3, b=0, op=011 (acc=3), then use_acc=1, b=4, op=000 → 0111, then use_acc=1, b=7, op=100 → 0000, zero=1.
- Illegal opcode: push op=101, a=F, b=F → rsp_result=0000, rsp_zero=1, rsp_illegal=1. The next legal op clears rsp_illegal.
- Backpressure/full:
  - Hold rsp_ready=0 and push 5 commands with FIFO_DEPTH=4. After 4 pushes plus 1 pop, cmd_level=4 and cmd_ready=0. The 6th offer is stalled, and rsp_* stay stable.
  - Release rsp_ready: all responses return in order, with 3-cycle spacing.
- Reset mid-op: assert rst during EXEC with 2 entries queued → next cycle rsp_valid=0, cmd_level=0, acc=0. A following use_acc op with b=6, op=000 returns 0110.
